// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : shared constants, opcodes and FSM encoding for alu_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND  = 4'd0;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'd1;
    localparam logic [CTRL_W-1:0] ALU_ADDU = 4'd4;
    localparam logic [CTRL_W-1:0] ALU_SUBU = 4'd5;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic logic op_legal(input logic [CTRL_W-1:0] ctrl);
        logic legal;
        legal = 1'b0;
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADDU, ALU_SUBU, ALU_SLT: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
// ============================================================================
// alu_arbiter_alu : shared combinational 32-bit ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int CTRL_W_P = CTRL_W
) (
    input  logic [DATA_W_P-1:0] src1_i,
    input  logic [DATA_W_P-1:0] src2_i,
    input  logic [CTRL_W_P-1:0] ctrl_i,
    output logic [DATA_W_P-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (ctrl_i)
            ALU_AND:  result_o = src1_i & src2_i;
            ALU_OR:   result_o = src1_i | src2_i;
            ALU_ADDU: result_o = src1_i + src2_i;
            ALU_SUBU: result_o = src1_i - src2_i;
            ALU_SLT:  result_o = {{(DATA_W_P-1){1'b0}}, (src1_i < src2_i)};
            default:  result_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : two-port valid/ready arbiter sharing one ALU, registered result.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin, otherwise port 0 has priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int CTRL_W_P = CTRL_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic [1:0]               req_valid_i,
    output logic [1:0]               req_ready_o,
    input  logic [1:0][DATA_W_P-1:0] req_src1_i,
    input  logic [1:0][DATA_W_P-1:0] req_src2_i,
    input  logic [1:0][CTRL_W_P-1:0] req_ctrl_i,
    output logic [1:0]               rsp_valid_o,
    input  logic [1:0]               rsp_ready_i,
    output logic [DATA_W_P-1:0]      rsp_result_o,
    output logic                     rsp_zero_o
);

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [DATA_W_P-1:0]   result_q, result_d;
    logic                  zero_q, zero_d;

    logic                  grant;
    logic                  can_accept;
    logic                  accept;
    logic [DATA_W_P-1:0]   alu_src1;
    logic [DATA_W_P-1:0]   alu_src2;
    logic [CTRL_W_P-1:0]   alu_ctrl;
    logic [DATA_W_P-1:0]   alu_result;
    logic [DATA_W_P-1:0]   capture;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;

    // rr_q names the preferred port; fall back to the other one when it is idle.
    always_comb begin
        grant = req_valid_i[rr_q] ? rr_q : ~rr_q;
        rr_d  = accept ? ~grant : rr_q;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        grant = ~req_valid_i[0];
    end
`endif

    // A full result register frees up in the same cycle its owner takes it.
    always_comb begin
        can_accept         = (state_q == ST_IDLE) | rsp_ready_i[owner_q];
        req_ready_o        = 2'b00;
        req_ready_o[grant] = req_valid_i[grant] & can_accept;
        accept             = req_valid_i[grant] & can_accept;
    end

    always_comb begin
        alu_src1 = req_src1_i[grant];
        alu_src2 = req_src2_i[grant];
        alu_ctrl = req_ctrl_i[grant];
    end

    alu_arbiter_alu #(
        .DATA_W_P (DATA_W_P),
        .CTRL_W_P (CTRL_W_P)
    ) u_alu (
        .src1_i   (alu_src1),
        .src2_i   (alu_src2),
        .ctrl_i   (alu_ctrl),
        .result_o (alu_result)
    );

    // Unsupported opcodes are still accepted but always yield zero.
    always_comb begin
        capture = op_legal(alu_ctrl) ? alu_result : '0;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d = ST_HOLD;
                end else if (rsp_ready_i[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            owner_d  = grant;
            result_d = capture;
            zero_d   = (capture == '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        rsp_valid_o = 2'b00;
        if (state_q == ST_HOLD) begin
            rsp_valid_o[owner_q] = 1'b1;
        end
    end

    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : directed + randomized self-checking bench for alu_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  src1;
    logic [1:0][31:0]  src2;
    logic [1:0][3:0]   ctrl;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [31:0]       rsp_result;
    logic              rsp_zero;

    int checks = 0;
    int errors = 0;

    // Reference model state: is a result pending, whose, and what it is.
    logic        m_full;
    logic        m_owner;
    logic [31:0] m_res;
    logic        m_zero;
    logic        m_rr;
    logic [1:0]  last_acc;
    logic [1:0]  prev_acc;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_src1_i   (src1),
        .req_src2_i   (src2),
        .req_ctrl_i   (ctrl),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_zero_o   (rsp_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd4:    return a + b;
            4'd5:    return a - b;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_pick(input logic [1:0] v);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (v[m_rr]) return m_rr;
        return !m_rr;
`else
        if (v[0]) return 1'b0;
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_full  = 1'b0;
        m_owner = 1'b0;
        m_res   = 32'd0;
        m_zero  = 1'b0;
        m_rr    = 1'b0;
    endtask

    // One clock: check outputs at the negedge, advance the model at the posedge.
    task automatic cycle();
        logic       g;
        logic       can;
        logic [1:0] er;
        @(negedge clk);
        g   = ref_pick(req_valid);
        can = !m_full || rsp_ready[m_owner];
        er  = 2'b00;
        if (req_valid[g] && can) er[g] = 1'b1;
        chk("req_ready", {30'd0, req_ready}, {30'd0, er});
        chk("rsp_valid", {30'd0, rsp_valid}, m_full ? (32'd1 << m_owner) : 32'd0);
        if (m_full) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
        end
        last_acc = er;
        @(posedge clk);
        if (er != 2'b00) begin
            m_full  = 1'b1;
            m_owner = g;
            m_res   = ref_op(ctrl[g], src1[g], src2[g]);
            m_zero  = (m_res == 32'd0);
            m_rr    = !g;
        end else if (m_full && rsp_ready[m_owner]) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(input int k, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b);
        ctrl[k] = c;
        src1[k] = a;
        src2[k] = b;
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [8];
        ops = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd2, 4'd15};
        return ops[$urandom_range(0, 7)];
    endfunction

    function automatic logic [31:0] rand_data();
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        src1      = '0;
        src2      = '0;
        ctrl      = '0;
        last_acc  = 2'b00;
        prev_acc  = 2'b00;
        model_reset();

        // Reset state
        #22;
        chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset_result", rsp_result, 32'd0);
        chk("reset_zero", {31'd0, rsp_zero}, 32'd0);
        chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester, port 1 SUBU 3-5, held under backpressure
        set_req(1, 4'd5, 32'd3, 32'd5);
        req_valid = 2'b10;
        cycle();
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            chk("subu_valid", {30'd0, rsp_valid}, 32'd2);
            chk("subu_result", rsp_result, 32'hFFFF_FFFE);
            chk("subu_zero", {31'd0, rsp_zero}, 32'd0);
            cycle();
        end
        rsp_ready = 2'b11;
        cycle();
        rsp_ready = 2'b00;

        // Reset while holding a result
        set_req(0, 4'd4, 32'd5, 32'd7);
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        chk("addu_result", rsp_result, 32'd12);
        chk("addu_valid", {30'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {30'd0, rsp_valid}, 32'd0);
        chk("midrst_result", rsp_result, 32'd0);
        chk("midrst_zero", {31'd0, rsp_zero}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_req(0, 4'd0, 32'hFF, 32'h0F);
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        cycle();
        req_valid = 2'b00;
        chk("post_rst_result", rsp_result, 32'h0F);
        chk("post_rst_valid", {30'd0, rsp_valid}, 32'd1);
        cycle();

        // Contention with both responses always taken
        set_req(0, 4'd6, 32'd1, 32'd2);
        set_req(1, 4'd0, 32'hF0, 32'h0F);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        prev_acc  = 2'b00;
        for (int i = 0; i < 8; i++) begin
            cycle();
`ifdef ALU_ARB_ROUND_ROBIN_EN
            if (prev_acc != 2'b00) chk("rr_alternate", {30'd0, last_acc}, {30'd0, ~prev_acc});
`else
            chk("fixed_prio", {30'd0, last_acc}, 32'd1);
`endif
            prev_acc = last_acc;
            if (last_acc == 2'b01) begin
                chk("slt_result", rsp_result, 32'd1);
                chk("slt_zero", {31'd0, rsp_zero}, 32'd0);
            end else if (last_acc == 2'b10) begin
                chk("and_result", rsp_result, 32'd0);
                chk("and_zero", {31'd0, rsp_zero}, 32'd1);
            end
        end
        req_valid = 2'b10;
        cycle();
        chk("p1_after_drop", {30'd0, last_acc}, 32'd2);
        req_valid = 2'b00;
        cycle();

        // Backpressure on port 0 blocks port 1 until the handshake
        set_req(0, 4'd1, 32'h1234_0000, 32'h0000_5678);
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        cycle();
        set_req(1, 4'd4, 32'd1, 32'd2);
        req_valid = 2'b10;
        cycle();
        chk("bp_blocked", {30'd0, req_ready}, 32'd0);
        chk("bp_held", rsp_result, 32'h1234_5678);
        rsp_ready = 2'b01;
        #1;
        chk("bp_release", {30'd0, req_ready}, 32'd2);
        cycle();
        req_valid = 2'b00;
        chk("bp_p1_valid", {30'd0, rsp_valid}, 32'd2);
        chk("bp_p1_result", rsp_result, 32'd3);

        // Unsupported opcode
        set_req(0, 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        cycle();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        chk("illegal_result", rsp_result, 32'd0);
        chk("illegal_zero", {31'd0, rsp_zero}, 32'd1);
        chk("illegal_valid", {30'd0, rsp_valid}, 32'd1);
        cycle();

        // Randomized traffic; a request stays put until it is accepted
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (last_acc[k] || !req_valid[k]) begin
                    req_valid[k] = ($urandom_range(0, 3) != 0);
                    set_req(k, rand_op(), rand_data(), rand_data());
                end
            end
            rsp_ready = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU between two independent requesters (port 0, port 1) using valid/ready handshakes on both request and response sides. Accepted operations are executed by the shared ALU, then captured in a result register that is held until the owning requester takes it. The block sits between pipeline/control logic that needs occasional arithmetic (e.g. address calc, compare unit) and the single ALU instance.

## Interface
- DATA_W, 32, operand/result width; must equal the ALU width (32)
- CTRL_W, 4, ALU opcode width
- clk_i  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i[k]  in  1  requester k (k=0,1) presents an operation
- req_ready_o[k]  out  1  arbiter accepts requester k this cycle
- req_src1_i[k], req_src2_i[k]  in  DATA_W  operands of requester k
- req_ctrl_i[k]  in  CTRL_W  ALU opcode of requester k
- rsp_valid_o[k]  out  1  result register holds requester k's result
- rsp_ready_i[k]  in  1  requester k consumes its result
- rsp_result_o  out  DATA_W  registered result (shared bus, qualified by rsp_valid_o)
- rsp_zero_o  out  1  registered zero flag (result == 0)

## Operation
- States: IDLE (result register empty), HOLD (result register full, owner recorded in owner_q).
- Grant (combinational): among requesters with req_valid_i high, pick one per arbitration policy; req_ready_o[g] high only for granted g, and only when state==IDLE or (state==HOLD and rsp_ready_i[owner_q]).
- Accept = req_valid_i[g] & req_ready_o[g]. On accept: operands/ctrl of g drive the ALU, result and zero captured, owner_q<=g, state<=HOLD.
- HOLD: rsp_valid_o[owner_q]=1, other rsp_valid_o=0. Result/zero stable until handshake. rsp_ready_i of non-owner is ignored.
- HOLD and owner handshake with no accept -> IDLE. Handshake and accept in same cycle -> stay HOLD with new result/owner (back-to-back, one op per cycle).
- Supported opcodes: 0 AND, 1 OR, 4 ADDU, 5 SUBU, 6 SLT (unsigned compare, result {31'b0, src1<src2}). Any other code: accepted, result 0, zero 1; ALU output is not used for these codes.
- ADDU/SUBU wrap modulo 2^32, no carry/overflow output.
- Requester must hold req_* stable while req_valid_i high and not accepted; arbiter may switch grant between cycles while neither is accepted.
- Reset (any time, including HOLD): state IDLE, owner_q 0, result 0, zero 0, rr pointer 0; pending result discarded, no rsp_valid_o.

## Timing
- Reset values: req_ready_o = 2'b00 until first edge after rst_n release is not required; req_ready_o is combinational and high in IDLE for the granted valid requester; rsp_valid_o=2'b00, rsp_result_o=0, rsp_zero_o=0.
- Latency: accept at edge N -> rsp_valid_o high after edge N (visible cycle N+1).
- Throughput: 1 op/cycle when owner keeps rsp_ready_i high.
- No combinational path from req_* to rsp_*; rsp_ready_i -> req_ready_o is combinational (one gate level).

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined: round-robin; pointer rr_q names the preferred requester, after each accept rr_q <= ~g. Simultaneous requests alternate 0,1,0,1.
- Not defined: fixed priority, port 0 always wins; port 1 served only when req_valid_i[0] low. rr_q not instantiated.

## Structure
- Shared package alu_pkg: opcode localparams (ALU_AND=0, ALU_OR=1, ALU_ADDU=4, ALU_SUBU=5, ALU_SLT=6), DATA_W/CTRL_W constants, state encoding (ST_IDLE, ST_HOLD).
- One sub-module: the existing ALU, instantiated once; arbiter adds operand mux, opcode legality check, result register, FSM.

## Test plan
- Reset mid-HOLD: accept port 0 ADDU 5+7, assert rst_n=0 before rsp_ready -> rsp_valid_o=00, result 0, next op proceeds normally.
- Single requester: port 1 SUBU 3-5 -> next cycle rsp_valid_o=10, result 0xFFFFFFFE, zero 0; held 3 cycles with rsp_ready low, stable.
- Contention, macro defined: both valid continuously, both rsp_ready high -> grants 0,1,0,1 one per cycle; SLT 1<2 on port 0 gives 1, AND 0xF0&0x0F on port 1 gives 0, zero 1.
- Contention, macro undefined: same stimulus -> port 0 granted every cycle, port 1 ready stays 0 until port 0 valid drops.
- Backpressure: port 0 result held, rsp_ready_i[0]=0, port 1 valid -> req_ready_o[1]=0; raise rsp_ready_i[0] -> same cycle port 1 accepted, next cycle rsp_valid_o=10.
- Illegal opcode 7 with src1=src2=0xFFFFFFFF -> accepted, result 0, zero 1.
